// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants, FSM state type and error codes for the UART frame parser
package uart_pkg;

  localparam logic [7:0] SOF = 8'hA5;

  typedef enum logic [2:0] {
    HUNT,
    LEN,
    PAYLOAD,
    CHECK,
    DRAIN
  } state_t;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_BADLEN  = 3'd1;
  localparam logic [2:0] ERR_CHKSUM  = 3'd2;
  localparam logic [2:0] ERR_OVERRUN = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT = 3'd4;

endpackage

// File: rtl/uart_frame_buf.sv
// rtl/uart_frame_buf.sv - payload store: one write port, one registered read port
module uart_frame_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read data only moves on rd_en, so it doubles as the held output byte.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data <= 8'h00;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/uart_frame_rx.sv
// rtl/uart_frame_rx.sv - byte-to-frame parser with checksum and buffered drain; UART_FRAME_TIMEOUT_EN adds an inter-byte timeout
module uart_frame_rx
  import uart_pkg::*;
#(
  parameter int MAX_LEN     = 16,
  parameter int TIMEOUT_CYC = 100_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       m_last,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [2:0] err_code
);

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  state_t state_q, state_d;

  logic          rx_done_q;
  logic          byte_stb;
  logic [LW-1:0] len;
  logic [LW-1:0] idx;
  logic [LW-1:0] rd_idx;
  logic [LW-1:0] rd_next;
  logic [7:0]    chk;
  logic          xfer;
  logic          tmo_hit;

  logic          load_len;
  logic          wr_en;
  logic          chk_ok;
  logic          advance;
  logic [2:0]    err_d;
  logic          rd_en;
  logic [AW-1:0] rd_addr;

  assign byte_stb = rx_done & ~rx_done_q;
  assign xfer     = m_valid & m_ready;
  assign rd_next  = rd_idx + LW'(1);
  assign rd_en    = chk_ok | advance;
  assign rd_addr  = chk_ok ? '0 : rd_next[AW-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    load_len = 1'b0;
    wr_en    = 1'b0;
    chk_ok   = 1'b0;
    advance  = 1'b0;
    err_d    = ERR_NONE;
    case (state_q)
      HUNT: begin
        if (byte_stb && rx_data == SOF) state_d = LEN;
      end
      LEN: begin
        if (byte_stb) begin
          if (rx_data == 8'h00 || rx_data > MAX_LEN_B) begin
            err_d   = ERR_BADLEN;
            state_d = HUNT;
          end else begin
            load_len = 1'b1;
            state_d  = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (byte_stb) begin
          wr_en = 1'b1;
          if (idx + LW'(1) == len) state_d = CHECK;
        end
      end
      CHECK: begin
        if (byte_stb) begin
          if (rx_data == chk) begin
            chk_ok  = 1'b1;
            state_d = DRAIN;
          end else begin
            err_d   = ERR_CHKSUM;
            state_d = HUNT;
          end
        end
      end
      DRAIN: begin
        // Bytes arriving mid-drain are dropped; the drain itself is unaffected.
        if (byte_stb) err_d = ERR_OVERRUN;
        if (xfer) begin
          if (m_last) state_d = HUNT;
          else        advance = 1'b1;
        end
      end
      default: state_d = HUNT;
    endcase
    if (tmo_hit) begin
      err_d   = ERR_TIMEOUT;
      state_d = HUNT;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_done_q <= 1'b1;
      len       <= '0;
      idx       <= '0;
      rd_idx    <= '0;
      chk       <= 8'h00;
      m_valid   <= 1'b0;
      m_last    <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      rx_done_q <= rx_done;
      frame_ok  <= chk_ok;
      frame_err <= (err_d != ERR_NONE);
      err_code  <= err_d;
      if (load_len) begin
        len <= rx_data[LW-1:0];
        chk <= rx_data;
        idx <= '0;
      end else if (wr_en) begin
        chk <= chk ^ rx_data;
        idx <= idx + LW'(1);
      end
      if (chk_ok) begin
        m_valid <= 1'b1;
        m_last  <= (len == LW'(1));
        rd_idx  <= '0;
      end else if (xfer && m_last) begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end else if (advance) begin
        rd_idx <= rd_next;
        m_last <= (rd_next + LW'(1) == len);
      end
    end
  end

`ifdef UART_FRAME_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_cnt;
  logic          tmo_run;

  assign tmo_run = (state_q == LEN) || (state_q == PAYLOAD) || (state_q == CHECK);
  assign tmo_hit = tmo_run && !byte_stb && (tmo_cnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (tmo_run && !byte_stb) begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end else begin
      tmo_cnt <= '0;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  uart_frame_buf #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (idx[AW-1:0]),
    .wr_data (rx_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (m_data)
  );

endmodule
